uram_xor_rmw_issuer: RTL and testbench

Read-modify-write front end for the per-lane URAM bucket store. It accepts XOR-update requests (index, per-lane operand, lane mask) over a valid/ready handshake and reads the addressed row. It XORs the returned lanes with the operands and issues the write-back to the store's delayed write port. A shift-register scoreboard holds back any request whose index still has an update in flight, so no read ever returns stale data and no manual forwarding is required.

---
 rtl/uram_xor_rmw_issuer.sv | 144 ++++++++++++++
 tb/tb_uram_xor_rmw_issuer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_xor_rmw_issuer.sv
// uram_xor_rmw_issuer
//   Read-modify-write front end for the per-lane URAM bucket store. Accepts
//   XOR-update requests, reads the addressed row, XORs the selected lanes with
//   the request operand and issues the write-back. A shift-register scoreboard
//   holds back any request whose index still has an update in flight, so the
//   store's delayed write port never returns stale data to a later read.
//
// Ports
//   i_clk, i_rst_n              clock, async active-low reset
//   i_in_valid / o_in_ready     request handshake
//   i_in_index/xor/mask         request payload (lane i at [i*DATA_WIDTH +: DATA_WIDTH])
//   o_rd_valid, o_rd_index      read strobe/address to the store
//   i_rd_data                   store read data, RD_LATENCY cycles after o_rd_valid
//   o_wr_valid/index/data/mask  write-back to the store
//   o_stall_count               saturating count of cycles with in_valid & !in_ready
module uram_xor_rmw_issuer #(
    parameter int NUM_MUL     = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LATENCY  = 2,
    parameter int WR_LATENCY  = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [INDEX_WIDTH-1:0]        i_in_index,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] i_in_xor,
    input  logic [NUM_MUL-1:0]            i_in_mask,
    output logic                          o_rd_valid,
    output logic [INDEX_WIDTH-1:0]        o_rd_index,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] i_rd_data,
    output logic                          o_wr_valid,
    output logic [INDEX_WIDTH-1:0]        o_wr_index,
    output logic [NUM_MUL*DATA_WIDTH-1:0] o_wr_data,
    output logic [NUM_MUL-1:0]            o_wr_mask,
    output logic [31:0]                   o_stall_count
);

    localparam int SB_DEPTH = RD_LATENCY + WR_LATENCY;
    // Stage 0 is the read stage; the last stage lines up with i_rd_data.
    localparam int PIPE     = RD_LATENCY + 1;
    localparam int ROW_W    = NUM_MUL * DATA_WIDTH;

    logic [SB_DEPTH-1:0]    r_sb_valid;
    logic [INDEX_WIDTH-1:0] r_sb_index [SB_DEPTH];

    logic [PIPE-1:0]        r_p_valid;
    logic [INDEX_WIDTH-1:0] r_p_index [PIPE];
    logic [ROW_W-1:0]       r_p_xor   [PIPE];
    logic [NUM_MUL-1:0]     r_p_mask  [PIPE];

    logic                   r_wr_valid;
    logic [INDEX_WIDTH-1:0] r_wr_index;
    logic [ROW_W-1:0]       r_wr_data;
    logic [NUM_MUL-1:0]     r_wr_mask;
    logic [31:0]            r_stall_count;

    logic                   w_hazard;
    logic                   w_in_ready;
    logic                   w_accept;
    logic [ROW_W-1:0]       w_wr_data;

    // Every scoreboard entry blocks: the oldest one leaves on the next edge, so
    // a same-index request is first accepted SB_DEPTH+1 cycles after its
    // predecessor, which puts its read exactly WR_LATENCY after the prior write.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_sb_valid[i] && (r_sb_index[i] == i_in_index)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_in_ready = i_rst_n & ~w_hazard;
    assign w_accept   = i_in_valid & w_in_ready;

    always_comb begin
        w_wr_data = i_rd_data;
        for (int i = 0; i < NUM_MUL; i++) begin
            if (r_p_mask[PIPE-1][i]) begin
                w_wr_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    i_rd_data[i*DATA_WIDTH +: DATA_WIDTH] ^
                    r_p_xor[PIPE-1][i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sb_valid <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb_index[i] <= '0;
            end
            r_p_valid <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_p_index[i] <= '0;
                r_p_xor[i]   <= '0;
                r_p_mask[i]  <= '0;
            end
            r_wr_valid    <= 1'b0;
            r_wr_index    <= '0;
            r_wr_data     <= '0;
            r_wr_mask     <= '0;
            r_stall_count <= '0;
        end else begin
            r_sb_valid    <= {r_sb_valid[SB_DEPTH-2:0], w_accept};
            r_sb_index[0] <= i_in_index;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sb_index[i] <= r_sb_index[i-1];
            end

            r_p_valid    <= {r_p_valid[PIPE-2:0], w_accept};
            r_p_index[0] <= i_in_index;
            r_p_xor[0]   <= i_in_xor;
            r_p_mask[0]  <= i_in_mask;
            for (int i = 1; i < PIPE; i++) begin
                r_p_index[i] <= r_p_index[i-1];
                r_p_xor[i]   <= r_p_xor[i-1];
                r_p_mask[i]  <= r_p_mask[i-1];
            end

            r_wr_valid <= r_p_valid[PIPE-1];
            r_wr_index <= r_p_index[PIPE-1];
            r_wr_data  <= w_wr_data;
            r_wr_mask  <= r_p_mask[PIPE-1];

            if (i_in_valid && !w_in_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_rd_valid    = r_p_valid[0];
    assign o_rd_index    = r_p_index[0];
    assign o_wr_valid    = r_wr_valid;
    assign o_wr_index    = r_wr_index;
    assign o_wr_data     = r_wr_data;
    assign o_wr_mask     = r_wr_mask;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_uram_xor_rmw_issuer.sv
// tb_uram_xor_rmw_issuer
//   Drives XOR-update requests into uram_xor_rmw_issuer and models the URAM
//   store (2-cycle read, writes visible to reads 5 cycles later). Expected
//   reads/writes come from a reference row memory updated at accept time;
//   a negedge monitor pops and compares them when the DUT presents them.
module tb_uram_xor_rmw_issuer;

    typedef logic [255:0] row_t;
    typedef struct { int due; int idx; logic [3:0] mask; row_t data; } wr_t;
    typedef struct { int due; int idx; } rd_t;
    typedef struct { int due; row_t data; } rq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [11:0] i_in_index = '0;
    row_t        i_in_xor = '0;
    logic [3:0]  i_in_mask = '0;
    logic        o_rd_valid;
    logic [11:0] o_rd_index;
    row_t        i_rd_data = '0;
    logic        o_wr_valid;
    logic [11:0] o_wr_index;
    row_t        o_wr_data;
    logic [3:0]  o_wr_mask;
    logic [31:0] o_stall_count;

    uram_xor_rmw_issuer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_index(i_in_index), .i_in_xor(i_in_xor), .i_in_mask(i_in_mask),
        .o_rd_valid(o_rd_valid), .o_rd_index(o_rd_index), .i_rd_data(i_rd_data),
        .o_wr_valid(o_wr_valid), .o_wr_index(o_wr_index), .o_wr_data(o_wr_data),
        .o_wr_mask(o_wr_mask), .o_stall_count(o_stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int wr_count = 0;
    int exp_stall = 0;

    row_t st_mem  [int];   // store model contents
    row_t ref_mem [int];   // reference XOR accumulation
    int   last_acc [int];  // cycle of last accept per index
    wr_t  pend_wr [$];
    rq_t  rd_q    [$];
    wr_t  exp_wr  [$];
    rd_t  exp_rd  [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic row_t st_get(int idx);
        return st_mem.exists(idx) ? st_mem[idx] : '0;
    endfunction

    function automatic row_t ref_get(int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic ok, input row_t act, input row_t exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Store model, expected-ready model and scoreboard monitor.
    always @(negedge clk) begin
        wr_t  w;
        rd_t  r;
        row_t nw;
        row_t cur;
        int   idx;
        logic hz;
        // issued writes keep landing in the store regardless of DUT reset
        while (pend_wr.size() > 0 && pend_wr[0].due <= cyc) begin
            w = pend_wr.pop_front();
            cur = st_get(w.idx);
            for (int l = 0; l < 4; l++)
                if (w.mask[l]) cur[l*64 +: 64] = w.data[l*64 +: 64];
            st_mem[w.idx] = cur;
        end
        if (!rst_n) begin
            check("reset_outputs_zero",
                  {o_in_ready, o_rd_valid, o_rd_index, o_wr_valid, o_wr_index,
                   o_wr_data, o_wr_mask, o_stall_count} == '0,
                  row_t'({o_in_ready, o_rd_valid, o_wr_valid, o_wr_mask, o_stall_count}), '0);
            exp_wr.delete();
            exp_rd.delete();
            rd_q.delete();
            last_acc.delete();
            exp_stall = 0;
            i_rd_data = '0;
        end else begin
            if (o_rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_rd", 1'b0, row_t'(o_rd_index), '0);
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_timing_index", (r.due == cyc) && (int'(o_rd_index) == r.idx),
                          row_t'({cyc, 20'd0, o_rd_index}), row_t'({r.due, r.idx}));
                end
                rd_q.push_back('{cyc + 2, st_get(int'(o_rd_index))});
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                i_rd_data = rd_q[0].data;
                void'(rd_q.pop_front());
            end else begin
                i_rd_data = rand_row();
            end
            if (o_wr_valid) begin
                wr_count++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr", 1'b0, row_t'(o_wr_index), '0);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_timing_index_mask",
                          (w.due == cyc) && (int'(o_wr_index) == w.idx) && (o_wr_mask == w.mask),
                          row_t'({cyc, o_wr_index, o_wr_mask}), row_t'({w.due, w.idx[11:0], w.mask}));
                    check("wr_data", o_wr_data === w.data, o_wr_data, w.data);
                end
                pend_wr.push_back('{cyc + 5, int'(o_wr_index), o_wr_mask, o_wr_data});
            end
            if (i_in_valid) begin
                idx = int'(i_in_index);
                hz = last_acc.exists(idx) && (cyc - last_acc[idx] >= 1) && (cyc - last_acc[idx] <= 7);
                check("in_ready", o_in_ready === !hz, row_t'(o_in_ready), row_t'(!hz));
                if (o_in_ready) begin
                    acc_count++;
                    last_acc[idx] = cyc;
                    nw = ref_get(idx);
                    for (int l = 0; l < 4; l++)
                        if (i_in_mask[l]) nw[l*64 +: 64] ^= i_in_xor[l*64 +: 64];
                    ref_mem[idx] = nw;
                    exp_rd.push_back('{cyc + 1, idx});
                    exp_wr.push_back('{cyc + 4, idx, i_in_mask, nw});
                end else begin
                    exp_stall++;
                end
            end
        end
    end

    task automatic send(input int idx, input row_t x, input logic [3:0] m, output int stalls);
        stalls = 0;
        i_in_valid = 1'b1;
        i_in_index = idx[11:0];
        i_in_xor   = x;
        i_in_mask  = m;
        @(negedge clk);
        while (!o_in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!o_in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted index=%0d", idx);
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st;
        int   s0;
        row_t x1, x2, pre, exp_row, got;
        int   acc0, wr0;

        idle(3);
        rst_n = 1'b1;
        idle(2);

        // back-to-back distinct indices, rows start at zero
        s0 = int'(o_stall_count);
        for (int i = 1; i <= 4; i++) begin
            send(i, rand_row(), 4'hF, st);
            check("b2b_no_stall", st == 0, row_t'(st), '0);
        end
        idle(12);
        check("b2b_stall_count", int'(o_stall_count) == s0, row_t'(o_stall_count), row_t'(s0));
        for (int i = 1; i <= 4; i++)
            check("b2b_row", st_get(i) == ref_get(i), st_get(i), ref_get(i));

        // same index twice
        s0 = int'(o_stall_count);
        x1 = rand_row();
        x2 = rand_row();
        send(16, x1, 4'hF, st);
        send(16, x2, 4'hF, st);
        check("same_idx_stalls", st == 7, row_t'(st), row_t'(7));
        check("same_idx_stall_count", int'(o_stall_count) - s0 == 7,
              row_t'(o_stall_count), row_t'(s0 + 7));
        idle(12);
        check("same_idx_final", st_get(16) == (x1 ^ x2), st_get(16), x1 ^ x2);

        // same index, disjoint masks
        pre = rand_row();
        st_mem[48] = pre;
        ref_mem[48] = pre;
        send(48, x1, 4'b0001, st);
        send(48, x2, 4'b0010, st);
        check("disjoint_mask_stalls", st == 7, row_t'(st), row_t'(7));
        idle(12);
        exp_row = pre;
        exp_row[63:0]   = pre[63:0] ^ x1[63:0];
        exp_row[127:64] = pre[127:64] ^ x2[127:64];
        check("disjoint_mask_final", st_get(48) == exp_row, st_get(48), exp_row);

        // partial mask with known data
        pre = {4{64'h1234}};
        st_mem[64] = pre;
        ref_mem[64] = pre;
        send(64, {256{1'b1}}, 4'b0101, st);
        idle(12);
        got = st_get(64);
        exp_row = {64'h1234, 64'hFFFF_FFFF_FFFF_EDCB, 64'h1234, 64'hFFFF_FFFF_FFFF_EDCB};
        check("mask0101_row", got == exp_row, got, exp_row);

        // mid-flight reset drops the request
        wr0 = wr_count;
        send(32, rand_row(), 4'hF, st);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        ref_mem = st_mem;
        send(32, x1, 4'hF, st);
        check("post_reset_first_accept", st == 0, row_t'(st), '0);
        check("reset_dropped_wr", wr_count == wr0, row_t'(wr_count), row_t'(wr0));
        idle(12);
        check("post_reset_row", st_get(32) == ref_get(32), st_get(32), ref_get(32));
        check("post_reset_stall_count", o_stall_count == 32'd0, row_t'(o_stall_count), '0);

        // randomized traffic on a small index set, in_valid always high
        acc0 = acc_count;
        wr0 = wr_count;
        s0 = cyc;
        while (cyc - s0 < 10000)
            send($urandom_range(0, 7), rand_row(), 4'($urandom_range(0, 15)), st);
        idle(15);
        check("rand_wr_count", (wr_count - wr0) == (acc_count - acc0),
              row_t'(wr_count - wr0), row_t'(acc_count - acc0));
        for (int i = 0; i < 8; i++)
            check("rand_final_row", st_get(i) == ref_get(i), st_get(i), ref_get(i));
        check("rand_stall_count", int'(o_stall_count) == exp_stall,
              row_t'(o_stall_count), row_t'(exp_stall));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
